// File: rtl/fir_tdm_mac_if.sv
// Sample, coefficient and result signals of the time-multiplexed FIR.
// The master modport drives samples and coefficient writes; the slave modport is the filter.
interface fir_tdm_mac_if #(
  parameter int DATA_IN_WIDTH  = 16,
  parameter int TAP_WIDTH      = 32,
  parameter int DATA_OUT_WIDTH = 64,
  parameter int ADDR_WIDTH     = 6,
  parameter int CHAN_WIDTH     = 1
);
  logic                             coef_we;
  logic [ADDR_WIDTH-1:0]            coef_addr;
  logic signed [TAP_WIDTH-1:0]      coef_data;
  logic                             coef_drop;
  logic                             in_valid;
  logic                             in_ready;
  logic [CHAN_WIDTH-1:0]            in_chan;
  logic signed [DATA_IN_WIDTH-1:0]  data_in;
  logic                             out_valid;
  logic [CHAN_WIDTH-1:0]            out_chan;
  logic signed [DATA_OUT_WIDTH-1:0] data_out;

  modport master (
    output coef_we, coef_addr, coef_data, in_valid, in_chan, data_in,
    input  coef_drop, in_ready, out_valid, out_chan, data_out
  );

  modport slave (
    input  coef_we, coef_addr, coef_data, in_valid, in_chan, data_in,
    output coef_drop, in_ready, out_valid, out_chan, data_out
  );
endinterface

// File: rtl/fir_tdm_mac.sv
// Multi-channel FIR with one shared multiplier-accumulator stepping one tap per clock.
// Result TAP_COUNT cycles after accept; in_ready is low while the MAC runs; no output backpressure.
module fir_tdm_mac #(
  parameter int DATA_IN_WIDTH  = 16,
  parameter int TAP_WIDTH      = 32,
  parameter int TAP_COUNT      = 34,
  parameter int CHANNELS       = 2,
  parameter int DATA_OUT_WIDTH = 64
) (
  input  logic         clk,
  input  logic         reset_n,
  fir_tdm_mac_if.slave bus
);
  localparam int AW       = (TAP_COUNT > 1) ? $clog2(TAP_COUNT) : 1;
  localparam int CW       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int PW       = DATA_IN_WIDTH + TAP_WIDTH;
  localparam int K_LAST_I = TAP_COUNT - 1;
  localparam logic [AW-1:0] K_LAST = K_LAST_I[AW-1:0];
  localparam logic [AW:0]   N_ADDR = TAP_COUNT[AW:0];
  localparam logic [CW:0]   N_CHAN = CHANNELS[CW:0];

  typedef enum logic {IDLE, MAC} state_t;

  state_t state, state_nxt;

  logic signed [DATA_IN_WIDTH-1:0]  delay [CHANNELS][TAP_COUNT];
  logic signed [TAP_WIDTH-1:0]      coef  [TAP_COUNT];
  logic signed [DATA_OUT_WIDTH-1:0] acc;
  logic [AW-1:0]                    k;
  logic [CW-1:0]                    ch;

  logic                             out_valid_q;
  logic [CW-1:0]                    out_chan_q;
  logic signed [DATA_OUT_WIDTH-1:0] data_out_q;
  logic                             coef_drop_q;

  logic                             idle;
  logic                             chan_ok;
  logic                             addr_ok;
  logic                             accept;
  logic                             coef_ok;
  logic signed [DATA_IN_WIDTH-1:0]  tap_x;
  logic signed [TAP_WIDTH-1:0]      tap_h;
  logic signed [PW-1:0]             prod;
  logic signed [DATA_OUT_WIDTH-1:0] prod_ext;
  logic signed [DATA_OUT_WIDTH-1:0] acc_sum;

  assign idle    = (state == IDLE);
  assign chan_ok = ({1'b0, bus.in_chan} < N_CHAN);
  assign addr_ok = ({1'b0, bus.coef_addr} < N_ADDR);
  // An out-of-range channel still completes the handshake; only accept starts work.
  assign accept  = bus.in_valid & idle & chan_ok;
  assign coef_ok = bus.coef_we & idle & addr_ok;

  assign tap_x    = delay[ch][k];
  assign tap_h    = coef[k];
  assign prod     = PW'(tap_x) * PW'(tap_h);
  assign prod_ext = {{(DATA_OUT_WIDTH-PW){prod[PW-1]}}, prod};
  assign acc_sum  = acc + prod_ext;

  assign bus.in_ready  = idle;
  assign bus.out_valid = out_valid_q;
  assign bus.out_chan  = out_chan_q;
  assign bus.data_out  = data_out_q;
  assign bus.coef_drop = coef_drop_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = MAC;
      MAC:     if (k == K_LAST) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc         <= '0;
      k           <= '0;
      ch          <= '0;
      out_valid_q <= 1'b0;
      out_chan_q  <= '0;
      data_out_q  <= '0;
      coef_drop_q <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      coef_drop_q <= bus.coef_we & ~coef_ok;
      if (accept) begin
        acc <= '0;
        k   <= '0;
        ch  <= bus.in_chan;
      end else if (state == MAC) begin
        if (k == K_LAST) begin
          data_out_q  <= acc_sum;
          out_chan_q  <= ch;
          out_valid_q <= 1'b1;
        end else begin
          acc <= acc_sum;
          k   <= k + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int c = 0; c < CHANNELS; c++)
        for (int t = 0; t < TAP_COUNT; t++)
          delay[c][t] <= '0;
    end else if (accept) begin
      for (int t = TAP_COUNT - 1; t > 0; t--)
        delay[bus.in_chan][t] <= delay[bus.in_chan][t-1];
      delay[bus.in_chan][0] <= bus.data_in;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int t = 0; t < TAP_COUNT; t++)
        coef[t] <= '0;
    end else if (coef_ok) begin
      coef[bus.coef_addr] <= bus.coef_data;
    end
  end
endmodule

// File: tb/tb_fir_tdm_mac.sv
// Directed bench for fir_tdm_mac: vector tables for impulse/step/interleave plus
// hand sequences for coefficient rules, reset mid-MAC, handshake and invalid channel.
module tb_fir_tdm_mac;
  localparam int N  = 34;
  localparam int AW = 6;
  localparam int CW = 1;

  logic clk;
  logic reset_n;
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  typedef struct {
    int     set;
    int     ch;
    int     x;
    longint y;
  } vec_t;

  vec_t vecs[$];

  fir_tdm_mac_if #(.DATA_IN_WIDTH(16), .TAP_WIDTH(32), .DATA_OUT_WIDTH(64),
                   .ADDR_WIDTH(AW), .CHAN_WIDTH(CW)) bus ();
  fir_tdm_mac #(.DATA_IN_WIDTH(16), .TAP_WIDTH(32), .TAP_COUNT(N), .CHANNELS(2),
                .DATA_OUT_WIDTH(64)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  // Three channels need a 2-bit channel field, so an unused code (3) exists.
  fir_tdm_mac_if #(.DATA_IN_WIDTH(16), .TAP_WIDTH(32), .DATA_OUT_WIDTH(64),
                   .ADDR_WIDTH(1), .CHAN_WIDTH(2)) bus2 ();
  fir_tdm_mac #(.DATA_IN_WIDTH(16), .TAP_WIDTH(32), .TAP_COUNT(2), .CHANNELS(3),
                .DATA_OUT_WIDTH(64)) dut2 (.clk(clk), .reset_n(reset_n), .bus(bus2));

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=timeout required=event", name);
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!bus.in_ready && n < 4 * N) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) timeout_fail("wait_in_ready");
  endtask

  task automatic load_coef(input int k, input int val);
    wait_ready();
    bus.coef_we   = 1'b1;
    bus.coef_addr = AW'(k);
    bus.coef_data = val;
    @(negedge clk);
    bus.coef_we = 1'b0;
  endtask

  task automatic accept(input int ch, input int x);
    wait_ready();
    bus.in_valid = 1'b1;
    bus.in_chan  = CW'(ch);
    bus.data_in  = 16'(x);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  // Counts negedges from the one following the accept edge; a result after EN gives lat=N.
  task automatic wait_out(output longint y, output int oc, output int lat);
    lat = 0;
    while (!bus.out_valid && lat < N + 10) begin
      @(negedge clk);
      lat++;
    end
    if (!bus.out_valid) timeout_fail("wait_out_valid");
    y  = bus.data_out;
    oc = int'(bus.out_chan);
  endtask

  task automatic run_set(input int s);
    longint y;
    int     oc, lat;
    foreach (vecs[i]) begin
      if (vecs[i].set == s) begin
        accept(vecs[i].ch, vecs[i].x);
        wait_out(y, oc, lat);
        chk($sformatf("set%0d_v%0d_y", s, i), y, vecs[i].y);
        chk($sformatf("set%0d_v%0d_chan", s, i), oc, vecs[i].ch);
        if (s == 0) chk($sformatf("set%0d_v%0d_latency", s, i), lat, N);
      end
    end
  endtask

  task automatic acc2(input int ch, input int x);
    int n = 0;
    while (!bus2.in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    bus2.in_valid = 1'b1;
    bus2.in_chan  = 2'(ch);
    bus2.data_in  = 16'(x);
    @(negedge clk);
    bus2.in_valid = 1'b0;
  endtask

  task automatic wait2(output longint y, output int oc);
    int n = 0;
    while (!bus2.out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!bus2.out_valid) timeout_fail("wait2_out_valid");
    y  = bus2.data_out;
    oc = int'(bus2.out_chan);
  endtask

  initial begin
    vec_t   v;
    longint y;
    int     oc, lat, m, pulses;
    int     acc_t[$];

    reset_n = 1'b0;
    bus.coef_we = 1'b0;  bus.coef_addr = '0;  bus.coef_data = '0;
    bus.in_valid = 1'b0; bus.in_chan = '0;    bus.data_in = '0;
    bus2.coef_we = 1'b0; bus2.coef_addr = '0; bus2.coef_data = '0;
    bus2.in_valid = 1'b0; bus2.in_chan = '0;  bus2.data_in = '0;

    // set 0: impulse with h[k]=k+1 -> 1..N
    for (int i = 0; i < N; i++) begin
      v.set = 0; v.ch = 0; v.x = (i == 0) ? 1 : 0; v.y = i + 1;
      vecs.push_back(v);
    end
    // set 1: step of 32767 on ch1 with h=-1, then a lone 0 on ch0
    for (int i = 0; i < N + 1; i++) begin
      m = (i + 1 < N) ? i + 1 : N;
      v.set = 1; v.ch = 1; v.x = 32767; v.y = -32767 * longint'(m);
      vecs.push_back(v);
    end
    v.set = 1; v.ch = 0; v.x = 0; v.y = 0;
    vecs.push_back(v);
    // set 2: h=1, ch0 history all 0, ch1 history all 32767 entering this set
    for (int i = 0; i < 40; i++) begin
      m = (i + 1 < N) ? i + 1 : N;
      v.set = 2; v.ch = 0; v.x = 100; v.y = 100 * m;
      vecs.push_back(v);
      v.set = 2; v.ch = 1; v.x = -3; v.y = -3 * m + 32767 * (N - m);
      vecs.push_back(v);
    end

    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_data_out", bus.data_out, 0);
    chk("rst_out_chan", bus.out_chan, 0);
    chk("rst_coef_drop", bus.coef_drop, 0);

    for (int k = 0; k < N; k++) load_coef(k, k + 1);
    run_set(0);
    for (int k = 0; k < N; k++) load_coef(k, -1);
    run_set(1);
    for (int k = 0; k < N; k++) load_coef(k, 1);
    run_set(2);

    // Coefficient write during MAC is dropped
    accept(0, 100);
    bus.coef_we = 1'b1; bus.coef_addr = AW'(0); bus.coef_data = 50;
    @(negedge clk);
    bus.coef_we = 1'b0;
    chk("drop_in_mac", bus.coef_drop, 1);
    @(negedge clk);
    chk("drop_one_cycle", bus.coef_drop, 0);
    wait_out(y, oc, lat);
    chk("mac_write_ignored_y", y, 3400);

    // Out-of-range address is dropped
    wait_ready();
    bus.coef_we = 1'b1; bus.coef_addr = AW'(N); bus.coef_data = 50;
    @(negedge clk);
    bus.coef_we = 1'b0;
    chk("drop_addr_n", bus.coef_drop, 1);
    accept(0, 100);
    wait_out(y, oc, lat);
    chk("addr_n_ignored_y", y, 3400);

    // Write and accept in the same IDLE cycle: h[0]=5 applies to this MAC
    wait_ready();
    bus.coef_we = 1'b1; bus.coef_addr = AW'(0); bus.coef_data = 5;
    bus.in_valid = 1'b1; bus.in_chan = CW'(1); bus.data_in = 16'(-3);
    @(negedge clk);
    bus.coef_we = 1'b0; bus.in_valid = 1'b0;
    chk("same_cycle_no_drop", bus.coef_drop, 0);
    wait_out(y, oc, lat);
    chk("same_cycle_y", y, -114);
    chk("same_cycle_chan", oc, 1);

    // Reset asserted at E5 of a MAC
    accept(0, 100);
    repeat (4) @(negedge clk);
    @(posedge clk);
    #1 reset_n = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid", bus.out_valid, 0);
    chk("midrst_data_out", bus.data_out, 0);
    chk("midrst_out_chan", bus.out_chan, 0);
    chk("midrst_in_ready", bus.in_ready, 1);
    chk("midrst_coef_drop", bus.coef_drop, 0);
    @(negedge clk);
    reset_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < N + 3; i++) begin
      @(negedge clk);
      if (bus.out_valid) pulses++;
    end
    chk("midrst_no_result", pulses, 0);
    accept(0, 1);
    wait_out(y, oc, lat);
    chk("postrst_impulse_y", y, 0);
    chk("postrst_latency", lat, N);

    // in_valid held high: accepts spaced N+1 cycles
    bus.in_valid = 1'b1; bus.in_chan = CW'(0); bus.data_in = 16'(0);
    for (int c = 0; c < 4 * (N + 1) && acc_t.size() < 3; c++) begin
      if (bus.in_ready) acc_t.push_back(cyc);
      if (bus.out_valid) chk("ready_with_out_valid", bus.in_ready, 1);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    chk("hs_accept_count", acc_t.size(), 3);
    if (acc_t.size() == 3) begin
      chk("hs_gap1", acc_t[1] - acc_t[0], N + 1);
      chk("hs_gap2", acc_t[2] - acc_t[1], N + 1);
    end
    wait_out(y, oc, lat);

    // Invalid channel on the 3-channel, 2-tap instance
    bus2.coef_we = 1'b1; bus2.coef_addr = 1'b0; bus2.coef_data = 1;
    @(negedge clk);
    bus2.coef_addr = 1'b1;
    @(negedge clk);
    bus2.coef_we = 1'b0;
    acc2(0, 10);
    wait2(y, oc);
    chk("c3_first_y", y, 10);
    acc2(3, 5);
    chk("c3_invalid_stays_idle", bus2.in_ready, 1);
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (bus2.out_valid) pulses++;
    end
    chk("c3_invalid_no_output", pulses, 0);
    acc2(0, 7);
    wait2(y, oc);
    chk("c3_history_unchanged_y", y, 17);
    chk("c3_history_chan", oc, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
